// File: rtl/smbm_cmd_seq.sv
// rtl/smbm_cmd_seq.sv - request queue and one-shot opcode sequencer in front of smbm
//
// Buffers ADD/DELETE/READ requests in a small FIFO and issues them one at a
// time to smbm: a single-cycle opcode pulse, arguments held until done, then
// a response pulse in the cycle where smbm results are valid.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid / req_ready        request handshake
//   req_opcode                   000 ADD, 001 DELETE, 010 READ, others illegal
//   req_id, req_metric_val,
//   req_in, req_metricX,
//   req_opcode_in                request arguments
//   sm_opcode                    opcode to smbm, 3'b111 when idle
//   sm_id, sm_metric_val, sm_in,
//   sm_metricX, sm_opcode_in     registered arguments to smbm
//   sm_done                      completion from smbm
//   resp_valid / resp_opcode     one-cycle completion pulse and its opcode
//   err / err_code               one-cycle error pulse; 01 illegal, 10 timeout
//   busy                         FSM not idle or queue non-empty
//   count                        queue occupancy

module smbm_cmd_seq #(
    parameter int BIT_VEC_SIZE       = 512,
    parameter int BIT_VEC_SIZE_LOG   = 9,
    parameter int NUM_OF_METRICS     = 8,
    parameter int NUM_OF_METRICS_LOG = 3,
    parameter int FIFO_DEPTH         = 4,
    parameter int TIMEOUT            = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [2:0]                          req_opcode,
    input  logic [BIT_VEC_SIZE_LOG-1:0]         req_id,
    input  logic [NUM_OF_METRICS-1:0][7:0]      req_metric_val,
    input  logic [BIT_VEC_SIZE-1:0]             req_in,
    input  logic [NUM_OF_METRICS_LOG-1:0]       req_metricX,
    input  logic [2:0]                          req_opcode_in,
    output logic [2:0]                          sm_opcode,
    output logic [BIT_VEC_SIZE_LOG-1:0]         sm_id,
    output logic [NUM_OF_METRICS-1:0][7:0]      sm_metric_val,
    output logic [BIT_VEC_SIZE-1:0]             sm_in,
    output logic [NUM_OF_METRICS_LOG-1:0]       sm_metricX,
    output logic [2:0]                          sm_opcode_in,
    input  logic                                sm_done,
    output logic                                resp_valid,
    output logic [2:0]                          resp_opcode,
    output logic                                err,
    output logic [1:0]                          err_code,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH):0]         count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    localparam logic [2:0] OP_READ = 3'b010;
    localparam logic [2:0] OP_NONE = 3'b111;

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Queue storage; contents are don't-care until written, so no reset.
    logic [2:0]                       q_opcode     [FIFO_DEPTH];
    logic [BIT_VEC_SIZE_LOG-1:0]      q_id         [FIFO_DEPTH];
    logic [NUM_OF_METRICS-1:0][7:0]   q_metric_val [FIFO_DEPTH];
    logic [BIT_VEC_SIZE-1:0]          q_in         [FIFO_DEPTH];
    logic [NUM_OF_METRICS_LOG-1:0]    q_metricX    [FIFO_DEPTH];
    logic [2:0]                       q_opcode_in  [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    cur_op;

    logic accept;
    logic legal;
    logic push;
    logic pop;

    assign req_ready = !rst && (count < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign legal     = (req_opcode <= OP_READ);
    assign push      = accept && legal;
    // Pop only from IDLE so a request pushed this cycle is never seen until the next one.
    assign pop       = (state == ST_IDLE) && (count != '0);
    assign busy      = (state != ST_IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_opcode[wr_ptr]     <= req_opcode;
            q_id[wr_ptr]         <= req_id;
            q_metric_val[wr_ptr] <= req_metric_val;
            q_in[wr_ptr]         <= req_in;
            q_metricX[wr_ptr]    <= req_metricX;
            q_opcode_in[wr_ptr]  <= req_opcode_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= ST_IDLE;
            timer         <= '0;
            cur_op        <= '0;
            sm_opcode     <= OP_NONE;
            sm_id         <= '0;
            sm_metric_val <= '0;
            sm_in         <= '0;
            sm_metricX    <= '0;
            sm_opcode_in  <= '0;
            resp_valid    <= 1'b0;
            resp_opcode   <= '0;
            err           <= 1'b0;
            err_code      <= '0;
        end else begin
            resp_valid <= 1'b0;
            err        <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            // Illegal requests are dropped; a timeout below overrides this code.
            if (accept && !legal) begin
                err      <= 1'b1;
                err_code <= ERR_ILLEGAL;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        sm_opcode     <= q_opcode[rd_ptr];
                        cur_op        <= q_opcode[rd_ptr];
                        sm_id         <= q_id[rd_ptr];
                        sm_metric_val <= q_metric_val[rd_ptr];
                        sm_in         <= q_in[rd_ptr];
                        sm_metricX    <= q_metricX[rd_ptr];
                        sm_opcode_in  <= q_opcode_in[rd_ptr];
                        rd_ptr        <= rd_ptr + 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Opcode is a single-cycle pulse; smbm must not see it twice.
                    sm_opcode <= OP_NONE;
                    timer     <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sm_done) begin
                        resp_valid  <= 1'b1;
                        resp_opcode <= cur_op;
                        state       <= ST_SETTLE;
                    end else if (timer == TIMEOUT_C) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    // SETTLE: resp_valid is high during this cycle.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smbm_cmd_seq.sv
// tb/tb_smbm_cmd_seq.sv - directed self-checking bench for smbm_cmd_seq
module tb_smbm_cmd_seq;

    localparam int BV  = 512;
    localparam int BVL = 9;
    localparam int NM  = 8;
    localparam int NML = 3;
    localparam int FD  = 4;
    localparam int TO  = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_opcode;
    logic [BVL-1:0]       req_id;
    logic [NM-1:0][7:0]   req_metric_val;
    logic [BV-1:0]        req_in;
    logic [NML-1:0]       req_metricX;
    logic [2:0]           req_opcode_in;
    logic [2:0]           sm_opcode;
    logic [BVL-1:0]       sm_id;
    logic [NM-1:0][7:0]   sm_metric_val;
    logic [BV-1:0]        sm_in;
    logic [NML-1:0]       sm_metricX;
    logic [2:0]           sm_opcode_in;
    logic                 sm_done;
    logic                 resp_valid;
    logic [2:0]           resp_opcode;
    logic                 err;
    logic [1:0]           err_code;
    logic                 busy;
    logic [$clog2(FD):0]  count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    smbm_cmd_seq #(
        .BIT_VEC_SIZE(BV), .BIT_VEC_SIZE_LOG(BVL), .NUM_OF_METRICS(NM),
        .NUM_OF_METRICS_LOG(NML), .FIFO_DEPTH(FD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_id(req_id), .req_metric_val(req_metric_val), .req_in(req_in),
        .req_metricX(req_metricX), .req_opcode_in(req_opcode_in),
        .sm_opcode(sm_opcode), .sm_id(sm_id), .sm_metric_val(sm_metric_val),
        .sm_in(sm_in), .sm_metricX(sm_metricX), .sm_opcode_in(sm_opcode_in),
        .sm_done(sm_done), .resp_valid(resp_valid), .resp_opcode(resp_opcode),
        .err(err), .err_code(err_code), .busy(busy), .count(count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [BVL-1:0] id,
                           input logic [2:0] opin, input logic [NML-1:0] mx);
        req_valid     = 1'b1;
        req_opcode    = op;
        req_id        = id;
        req_opcode_in = opin;
        req_metricX   = mx;
        for (int i = 0; i < NM; i++) req_metric_val[i] = 8'(i + 1);
        req_in = {32{16'(id) ^ 16'hA5C3}};
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_id = '0;
        req_metric_val = '0; req_in = '0; req_metricX = '0; req_opcode_in = '0;
        sm_done = 1'b0;
        tick; tick;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b want 0", req_ready); end
        tests++; if (count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (sm_opcode !== 3'b111) begin fails++; $display("FAIL reset_sm_opcode: got %0b want 111", sm_opcode); end
        tests++; if (sm_id !== '0 || sm_in !== '0 || sm_metric_val !== '0) begin fails++; $display("FAIL reset_sm_args: id %0h want 0", sm_id); end
        tests++; if (resp_valid !== 1'b0 || resp_opcode !== 3'b000) begin fails++; $display("FAIL reset_resp: valid %0b op %0b want 0/000", resp_valid, resp_opcode); end
        tests++; if (err !== 1'b0 || err_code !== 2'b00) begin fails++; $display("FAIL reset_err: err %0b code %0b want 0/00", err, err_code); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        tick;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %0b want 1", req_ready); end
    endtask

    task automatic test_add;
        set_req(3'b000, 9'd5, 3'b000, 3'd0);
        tick; req_valid = 1'b0;                                    // cycle 1
        tests++; if (count !== 3'd1 || busy !== 1'b1 || sm_opcode !== 3'b111) begin fails++; $display("FAIL add_c1: count %0d busy %0b op %0b want 1/1/111", count, busy, sm_opcode); end
        tick;                                                      // cycle 2
        tests++; if (sm_opcode !== 3'b000 || sm_id !== 9'd5) begin fails++; $display("FAIL add_issue: op %0b id %0d want 000/5", sm_opcode, sm_id); end
        tests++; if (sm_metric_val[0] !== 8'd1 || sm_metric_val[7] !== 8'd8) begin fails++; $display("FAIL add_metrics: m0 %0d m7 %0d want 1/8", sm_metric_val[0], sm_metric_val[7]); end
        tests++; if (sm_in !== {32{16'h0005 ^ 16'hA5C3}}) begin fails++; $display("FAIL add_in: got %0h", sm_in[15:0]); end
        tick;                                                      // cycle 3
        tests++; if (sm_opcode !== 3'b111 || sm_id !== 9'd5) begin fails++; $display("FAIL add_c3: op %0b id %0d want 111/5", sm_opcode, sm_id); end
        tick; sm_done = 1'b1;                                      // cycle 4
        tests++; if (resp_valid !== 1'b0 || sm_id !== 9'd5) begin fails++; $display("FAIL add_c4: resp %0b id %0d want 0/5", resp_valid, sm_id); end
        tick; sm_done = 1'b0;                                      // cycle 5
        tests++; if (resp_valid !== 1'b1 || resp_opcode !== 3'b000 || sm_id !== 9'd5) begin fails++; $display("FAIL add_resp: valid %0b op %0b id %0d want 1/000/5", resp_valid, resp_opcode, sm_id); end
        tick;                                                      // cycle 6
        tests++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL add_c6: resp %0b busy %0b want 0/0", resp_valid, busy); end
    endtask

    task automatic test_read;
        set_req(3'b010, 9'd9, 3'b101, 3'd3);
        tick; req_valid = 1'b0;                                    // cycle 1
        tick;                                                      // cycle 2
        tests++; if (sm_opcode !== 3'b010 || sm_opcode_in !== 3'b101 || sm_metricX !== 3'd3) begin fails++; $display("FAIL read_issue: op %0b opin %0b mx %0d want 010/101/3", sm_opcode, sm_opcode_in, sm_metricX); end
        tick; sm_done = 1'b1;                                      // cycle 3
        tests++; if (sm_opcode !== 3'b111 || resp_valid !== 1'b0) begin fails++; $display("FAIL read_c3: op %0b resp %0b want 111/0", sm_opcode, resp_valid); end
        tick; sm_done = 1'b0;                                      // cycle 4
        tests++; if (resp_valid !== 1'b1 || resp_opcode !== 3'b010 || sm_opcode !== 3'b111) begin fails++; $display("FAIL read_resp: valid %0b op %0b smop %0b want 1/010/111", resp_valid, resp_opcode, sm_opcode); end
        tick;
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL read_c5: resp %0b want 0", resp_valid); end
    endtask

    task automatic test_illegal;
        logic [2:0] ops [2];
        int bad;
        ops[0] = 3'b011; ops[1] = 3'b111;
        for (int k = 0; k < 2; k++) begin
            set_req(ops[k], 9'd7, 3'b000, 3'd0);
            tick; req_valid = 1'b0;
            tests++; if (err !== 1'b1 || err_code !== 2'b01) begin fails++; $display("FAIL illegal_err op%0b: err %0b code %0b want 1/01", ops[k], err, err_code); end
            tests++; if (count !== '0 || busy !== 1'b0) begin fails++; $display("FAIL illegal_count op%0b: count %0d busy %0b want 0/0", ops[k], count, busy); end
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                tick;
                if (sm_opcode !== 3'b111 || err !== 1'b0 || resp_valid !== 1'b0) bad++;
            end
            tests++; if (bad != 0) begin fails++; $display("FAIL illegal_quiet op%0b: %0d bad cycles want 0", ops[k], bad); end
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        set_req(3'b000, 9'd10, 3'b000, 3'd0);
        tick; req_valid = 1'b0;                                    // cycle 1
        tick; tick;                                                // cycle 3, WAIT
        for (int k = 0; k < 4; k++) begin
            set_req(3'b001, 9'(11 + k), 3'b000, 3'd0);
            tick;
        end
        tests++; if (count !== 3'd4 || req_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: count %0d ready %0b want 4/0", count, req_ready); end
        set_req(3'b000, 9'd15, 3'b000, 3'd0);
        tick; req_valid = 1'b0;
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL b2b_blocked: count %0d want 4", count); end
        sm_done = 1'b1;
        tick; sm_done = 1'b0;                                      // SETTLE of id 10
        tests++; if (resp_valid !== 1'b1 || sm_id !== 9'd10) begin fails++; $display("FAIL b2b_first_resp: valid %0b id %0d want 1/10", resp_valid, sm_id); end
        for (int k = 0; k < 4; k++) begin
            bad = 0;
            if (sm_opcode !== 3'b111) bad++;                       // SETTLE
            tick;
            if (sm_opcode !== 3'b111) bad++;                       // IDLE
            tick;
            tests++; if (bad != 0 || sm_opcode !== 3'b001 || sm_id !== 9'(11 + k)) begin fails++; $display("FAIL b2b_issue%0d: op %0b id %0d gap_bad %0d want 001/%0d/0", k, sm_opcode, sm_id, bad, 11 + k); end
            tick; sm_done = 1'b1;
            tick; sm_done = 1'b0;
            tests++; if (resp_valid !== 1'b1 || resp_opcode !== 3'b001 || sm_id !== 9'(11 + k)) begin fails++; $display("FAIL b2b_resp%0d: valid %0b op %0b id %0d want 1/001/%0d", k, resp_valid, resp_opcode, sm_id, 11 + k); end
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (sm_opcode !== 3'b111 || resp_valid !== 1'b0) bad++;
        end
        tests++; if (bad != 0 || busy !== 1'b0 || count !== '0) begin fails++; $display("FAIL b2b_drain: bad %0d busy %0b count %0d want 0/0/0", bad, busy, count); end
    endtask

    task automatic test_timeout;
        int bad;
        set_req(3'b000, 9'd20, 3'b000, 3'd0);
        tick; req_valid = 1'b0;                                    // cycle 1
        tick;                                                      // cycle 2
        tests++; if (sm_opcode !== 3'b000) begin fails++; $display("FAIL to_issue: op %0b want 000", sm_opcode); end
        bad = 0;
        for (int c = 3; c <= 18; c++) begin
            tick;
            if (err !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL to_wait: %0d bad cycles want 0", bad); end
        set_req(3'b100, 9'd21, 3'b000, 3'd0);                      // illegal, same edge as timeout
        tick; req_valid = 1'b0;                                    // cycle 19
        tests++; if (err !== 1'b1 || err_code !== 2'b10) begin fails++; $display("FAIL to_err: err %0b code %0b want 1/10", err, err_code); end
        tests++; if (resp_valid !== 1'b0 || busy !== 1'b0 || count !== '0) begin fails++; $display("FAIL to_state: resp %0b busy %0b count %0d want 0/0/0", resp_valid, busy, count); end
        tick;
        tests++; if (err !== 1'b0 || sm_opcode !== 3'b111 || resp_valid !== 1'b0) begin fails++; $display("FAIL to_after: err %0b op %0b resp %0b want 0/111/0", err, sm_opcode, resp_valid); end
    endtask

    task automatic test_reset_midop;
        int bad;
        set_req(3'b000, 9'd30, 3'b000, 3'd0);
        tick; set_req(3'b001, 9'd31, 3'b000, 3'd0);                // cycle 1
        tick; set_req(3'b010, 9'd32, 3'b000, 3'd0);                // cycle 2
        tick; req_valid = 1'b0;                                    // cycle 3, WAIT
        tests++; if (count !== 3'd2 || sm_opcode !== 3'b111 || sm_id !== 9'd30) begin fails++; $display("FAIL rst_pre: count %0d op %0b id %0d want 2/111/30", count, sm_opcode, sm_id); end
        rst = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %0b want 0", req_ready); end
        tick;
        tests++; if (count !== '0 || sm_opcode !== 3'b111 || busy !== 1'b0 || sm_id !== '0) begin fails++; $display("FAIL rst_mid: count %0d op %0b busy %0b id %0d want 0/111/0/0", count, sm_opcode, busy, sm_id); end
        tests++; if (err !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_pulses: err %0b resp %0b want 0/0", err, resp_valid); end
        rst = 1'b0;
        sm_done = 1'b1;
        tick; sm_done = 1'b0;
        bad = 0;
        if (resp_valid !== 1'b0 || err !== 1'b0 || sm_opcode !== 3'b111) bad++;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (resp_valid !== 1'b0 || err !== 1'b0 || sm_opcode !== 3'b111 || busy !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL rst_after: %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_read;
        test_illegal;
        test_back_to_back;
        test_timeout;
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
